// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, PC step and
// instruction field bit positions.
package instr_fetch_unit_pkg;

  localparam int IW = 32;

  localparam logic [IW-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RETRY = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/instr_fetch_unit_split.sv
// Purely combinational R/I-type field split; decode can reuse it as-is.
module instr_field_split
  import instr_fetch_unit_pkg::*;
(
  input  logic [IW-1:0] instr,
  output logic [5:0]    opcode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    funct,
  output logic [15:0]   imm16
);

  // No sign/zero extension here; the downstream extender owns that.
  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/ack with timeout retry, instruction register
// handed to decode over valid/ready.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        misalign_err,
  output logic        fetch_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  fetch_state_e  state;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_nxt;

  // Count of WAIT cycles including the current one.
  assign tmo_nxt   = tmo_cnt + CW'(1);
  assign imem_addr = pc;

  // Fetch FSM; imem_req and dec_valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      instr         <= '0;
      tmo_cnt       <= '0;
      imem_req      <= 1'b0;
      dec_valid     <= 1'b0;
      misalign_err  <= 1'b0;
      fetch_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_WAIT;
          imem_req <= 1'b1;
        end
        ST_WAIT: begin
          // An ack on the expiry cycle takes priority over the retry.
          if (imem_ack) begin
            instr     <= imem_rdata;
            tmo_cnt   <= '0;
            imem_req  <= 1'b0;
            dec_valid <= 1'b1;
            state     <= ST_HOLD;
          end else if (tmo_nxt == CW'(TIMEOUT_CYCLES)) begin
            fetch_timeout <= 1'b1;
            tmo_cnt       <= '0;
            imem_req      <= 1'b0;
            state         <= ST_RETRY;
          end else begin
            tmo_cnt <= tmo_nxt;
          end
        end
        ST_RETRY: begin
          imem_req <= 1'b1;
          state    <= ST_WAIT;
        end
        ST_HOLD: begin
          if (dec_ready) begin
            if (redirect_valid) begin
              pc <= {redirect_pc[31:2], 2'b00};
              if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
            end else begin
              pc <= pc + PC_STEP;
            end
            dec_valid <= 1'b0;
            imem_req  <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        default: begin
          state     <= ST_IDLE;
          imem_req  <= 1'b0;
          dec_valid <= 1'b0;
        end
      endcase
    end
  end

  instr_field_split u_split (
    .instr  (instr),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: each accepted fetch pushes the
// expected {pc, word}; the entry is popped when decode sees dec_valid.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, dec_valid, dec_ready, redirect_valid;
  logic        misalign_err, fetch_timeout;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, pc, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  logic        exp_mis;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc(pc), .instr(instr), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
    .misalign_err(misalign_err), .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expects a pending request at exp_pc, acks it with word, then checks the
  // instruction register one cycle later against the scoreboard.
  task automatic do_ack(input logic [31:0] word);
    exp_t e;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL req_addr: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    sb.push_back('{pc: exp_pc, word: word});
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    checks++;
    if (dec_valid !== 1'b1) begin
      errors++;
      $display("FAIL dec_valid_after_ack: got %b want 1", dec_valid);
    end
    e = sb.pop_front();
    checks++;
    if (instr !== e.word || pc !== e.pc) begin
      errors++;
      $display("FAIL ir_pc: instr=%h pc=%h, want instr=%h pc=%h", instr, pc, e.word, e.pc);
    end
    checks++;
    if (opcode !== e.word[31:26] || rs !== e.word[25:21] || rt !== e.word[20:16] ||
        rd !== e.word[15:11] || shamt !== e.word[10:6] || funct !== e.word[5:0] ||
        imm16 !== e.word[15:0]) begin
      errors++;
      $display("FAIL fields: op=%h rs=%h rt=%h rd=%h sh=%h fn=%h imm=%h for word %h",
               opcode, rs, rt, rd, shamt, funct, imm16, e.word);
    end
  endtask

  // Handoff from HOLD; the next request must appear immediately.
  task automatic handoff(input logic rv, input logic [31:0] rpc);
    dec_ready      = 1'b1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    step();
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    if (rv) begin
      exp_pc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
    end else begin
      exp_pc = exp_pc + 32'd4;
    end
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc ||
        misalign_err !== exp_mis) begin
      errors++;
      $display("FAIL handoff: dv=%b req=%b addr=%h mis=%b, want dv=0 req=1 addr=%h mis=%b",
               dec_valid, imem_req, imem_addr, misalign_err, exp_pc, exp_mis);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    exp_pc = 32'h0; exp_mis = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || dec_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 ||
        opcode !== 6'h0 || imm16 !== 16'h0 || misalign_err !== 1'b0 || fetch_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b dv=%b pc=%h instr=%h mis=%b tmo=%b, want all 0",
               imem_req, dec_valid, pc, instr, misalign_err, fetch_timeout);
    end
    reset = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL first_req: req=%b want 1", imem_req);
    end
    do_ack(32'h3C01_1234);
    checks++;
    if (opcode !== 6'h0F || rt !== 5'd1 || imm16 !== 16'h1234) begin
      errors++;
      $display("FAIL lui_fields: op=%h rt=%h imm=%h want 0f 01 1234", opcode, rt, imm16);
    end
  endtask

  task automatic test_hold_stall;
    logic [31:0] i0, p0;
    int bad;
    i0 = instr; p0 = pc; bad = 0;
    // Redirect while not handing off must be ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0800;
    for (int k = 0; k < 5; k++) begin
      step();
      if (dec_valid !== 1'b1 || instr !== i0 || pc !== p0 || imem_req !== 1'b0) bad++;
    end
    redirect_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles, want 0", bad);
    end
    handoff(1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL addr_after_stall: got %h want 00000004", imem_addr);
    end
  endtask

  task automatic test_redirect;
    do_ack(32'h0123_4567);
    handoff(1'b1, 32'h0000_0102);
    checks++;
    if (imem_addr !== 32'h0000_0100 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_redirect: addr=%h mis=%b want 00000100 1", imem_addr, misalign_err);
    end
    do_ack(32'h8C22_0010);
    handoff(1'b1, 32'h0000_0200);
    checks++;
    if (misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_sticky: got %b want 1", misalign_err);
    end
  endtask

  task automatic test_wrap;
    do_ack(32'h0000_0020);
    handoff(1'b1, 32'hFFFF_FFFC);
    do_ack(32'hAC43_FFFF);
    handoff(1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: got %h want 00000000", imem_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w;
    dec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 32'h0000_0000 | (k << 11) | (k + 32);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        errors++;
        $display("FAIL b2b_req: k=%0d req=%b addr=%h want 1 %h", k, imem_req, imem_addr, exp_pc);
      end
      imem_ack = 1'b1; imem_rdata = w;
      sb.push_back('{pc: exp_pc, word: w});
      step();
      imem_ack = 1'b0;
      begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (dec_valid !== 1'b1 || instr !== e.word || pc !== e.pc) begin
          errors++;
          $display("FAIL b2b_ir: k=%0d dv=%b instr=%h pc=%h want 1 %h %h",
                   k, dec_valid, instr, pc, e.word, e.pc);
        end
      end
      step();
      exp_pc = exp_pc + 32'd4;
    end
    dec_ready = 1'b0;
  endtask

  task automatic test_ack_at_expiry;
    int drops;
    drops = 0;
    for (int k = 0; k < 254; k++) begin
      if (imem_req !== 1'b1) drops++;
      step();
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL req_before_expiry: %0d low cycles, want 0", drops);
    end
    do_ack(32'h2001_0005);
    checks++;
    if (fetch_timeout !== 1'b0) begin
      errors++;
      $display("FAIL ack_wins_expiry: tmo=%b want 0", fetch_timeout);
    end
    handoff(1'b0, 32'h0);
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    while (imem_req === 1'b1 && n < 300) begin
      n++;
      step();
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL timeout_len: req high %0d cycles want 255", n);
    end
    checks++;
    if (fetch_timeout !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL retry_state: tmo=%b req=%b want 1 0", fetch_timeout, imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL retry_rereq: req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_pc);
    end
    do_ack(32'h0043_2820);
    handoff(1'b0, 32'h0);
  endtask

  task automatic test_reset_in_wait;
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    reset = 1'b0;
    exp_pc = 32'h0; exp_mis = 1'b0;
    checks++;
    if (instr !== 32'h0 || dec_valid !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0 ||
        misalign_err !== 1'b0 || fetch_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_wait: instr=%h dv=%b pc=%h req=%b mis=%b tmo=%b want 0s",
               instr, dec_valid, pc, imem_req, misalign_err, fetch_timeout);
    end
    // ack still high during IDLE must be ignored
    step();
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || dec_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rereq_after_reset: req=%b dv=%b instr=%h addr=%h want 1 0 0 0",
               imem_req, dec_valid, instr, imem_addr);
    end
    do_ack(32'h3C02_ABCD);
  endtask

  initial begin
    test_reset();
    test_hold_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_ack_at_expiry();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the single-cycle R/I-type MIPS datapath.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Latches each returned word into an instruction register and presents the decoded fields to decode under a valid/ready handshake.
- The imm16 field feeds the immediate zero-extender; rs/rt/rd feed the register file; opcode/funct feed control.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- TIMEOUT_CYCLES, 255, cycles spent in WAIT without imem_ack before a retry.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until ack
- imem_addr  out  32  fetch address, equal to pc while imem_req=1
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- dec_valid  out  1  instruction register holds a valid instruction
- dec_ready  in  1  decode consumes the instruction this cycle
- redirect_valid  in  1  branch/jump target; sampled only at handoff
- redirect_pc  in  32  redirect target
- pc  out  32  address of the instruction currently held or being fetched
- instr  out  32  instruction register
- opcode  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- imm16  out  16  instr[15:0], to zero-extender
- misalign_err  out  1  sticky: a redirect target had pc[1:0]!=0
- fetch_timeout  out  1  sticky: at least one retry has occurred

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pc=RESET_PC, instr=0, timeout counter=0, and imem_req, dec_valid, misalign_err and fetch_timeout all 0. All field outputs read 0.
- Reset is valid in any state. An imem_ack arriving during or after reset while in IDLE is ignored.
- FSM states: IDLE, WAIT, RETRY, HOLD.
  - IDLE: outputs quiet; go to WAIT on the next cycle.
  - WAIT: imem_req=1, imem_addr=pc, timeout counter increments each cycle.
    - On imem_ack=1: instr<=imem_rdata, counter<=0, go to HOLD.
    - If the counter reaches TIMEOUT_CYCLES with no ack: fetch_timeout<=1, counter<=0, go to RETRY.
    - An ack in the same cycle the counter expires wins; the retry does not happen.
  - RETRY: imem_req=0 for exactly one cycle, then go to WAIT with the same pc.
  - HOLD: dec_valid=1; instr and all fields stay stable until handoff.
    - Handoff occurs on dec_ready=1.
    - If redirect_valid=1 at handoff: pc<={redirect_pc[31:2],2'b00}. If redirect_pc[1:0]!=0, set misalign_err.
    - Otherwise pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
    - After handoff go to WAIT.
  - redirect_valid outside a HOLD handoff cycle is ignored.
- dec_valid is registered and deasserts the cycle after handoff.
- Latency and throughput:
  - From an ack cycle to dec_valid=1 is 1 cycle.
  - With zero-wait memory and dec_ready tied high, one instruction completes every 2 cycles (WAIT, HOLD).
- Field outputs are combinational slices of instr. No extension is done here; zero-extension stays in the downstream extender.
- misalign_err and fetch_timeout clear only on reset.

Decomposition:
- Shared package contains:
  - state encoding (IDLE, WAIT, RETRY, HOLD, 2 bits)
  - PC_STEP=4
  - field bit-position constants for opcode, rs, rt, rd, shamt, funct, imm16
  - instruction word width (32)
- One natural sub-module: instr_field_split, a purely combinational split of instr into fields, reusable by decode.
- PC, FSM and timeout counter live in instr_fetch_unit.

Test Plan:
- Reset release, memory acks the first request immediately with 32'h3C01_1234 -> imem_addr=0 while req; next cycle dec_valid=1, opcode=6'h0F, rt=1, imm16=16'h1234.
- dec_ready held 0 for 5 cycles in HOLD -> instr and pc stable, no new imem_req; on dec_ready=1 -> next imem_addr=4.
- At handoff with redirect_valid=1, redirect_pc=32'h0000_0102 -> next imem_addr=32'h0000_0100 and misalign_err=1; a later aligned redirect leaves it set.
- pc=32'hFFFF_FFFC, handoff with no redirect -> next imem_addr=0.
- No ack for 255 cycles -> fetch_timeout=1, imem_req low exactly 1 cycle, then re-raised at the same address; an ack then completes normally.
- reset asserted in WAIT with ack arriving the same cycle -> instr=0, dec_valid=0, pc=RESET_PC; a new request is raised 1 cycle after reset deasserts.
